// File: rtl/grid_scan_if.sv
// Bundles the generation input, scan enable and the LED/status outputs of grid_scan.
interface grid_scan_if;
    logic [63:0] grid;
    logic        grid_valid;
    logic        enable;
    logic [7:0]  row_sel;
    logic [7:0]  col;
    logic        frame_done;
    logic [6:0]  live_count;
    logic        stable;
    logic        extinct;
    logic [15:0] gen_count;

    modport master (
        output grid, grid_valid, enable,
        input  row_sel, col, frame_done, live_count, stable, extinct, gen_count
    );

    modport slave (
        input  grid, grid_valid, enable,
        output row_sel, col, frame_done, live_count, stable, extinct, gen_count
    );
endinterface

// File: rtl/grid_scan.sv
// Row-multiplexed LED scan of the 8x8 Game-of-Life grid with a double-buffered
// display and per-generation status.
module grid_scan #(
    parameter int ROW_CYCLES   = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input logic     clk,
    input logic     reset,
    grid_scan_if.slave gs
);

    localparam int MAX_C = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       row;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      pend_buf;
    logic             pend;
    logic [63:0]      disp_buf;
    logic [63:0]      prev_gen;
    logic [7:0]       row_sel;
    logic [7:0]       col;
    logic             frame_done;
    logic [6:0]       live_count;
    logic             stable;
    logic             extinct;
    logic [15:0]      gen_count;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Row r lives in byte 7-r; since r is 3 bits, 7-r is simply ~r.
    function automatic logic [7:0] row_bits(input logic [63:0] g, input logic [2:0] r);
        return g[{~r, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BLANK;
            row        <= '0;
            cnt        <= '0;
            pend_buf   <= '0;
            pend       <= 1'b0;
            disp_buf   <= '0;
            prev_gen   <= '0;
            row_sel    <= '0;
            col        <= '0;
            frame_done <= 1'b0;
            live_count <= '0;
            stable     <= 1'b0;
            extinct    <= 1'b1;
            gen_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!gs.enable) begin
                state   <= IDLE;
                row     <= '0;
                cnt     <= '0;
                row_sel <= '0;
                col     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= BLANK;
                        row        <= '0;
                        cnt        <= '0;
                        row_sel    <= '0;
                        col        <= '0;
                        frame_done <= 1'b1;
                        if (pend) begin
                            disp_buf <= pend_buf;
                            pend     <= 1'b0;
                        end
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state   <= DRIVE;
                            cnt     <= '0;
                            row_sel <= 8'd1 << row;
                            col     <= row_bits(disp_buf, row);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DRIVE: begin
                        if (cnt == ROW_LAST) begin
                            state   <= BLANK;
                            cnt     <= '0;
                            row     <= row + 3'd1;
                            row_sel <= '0;
                            col     <= '0;
                            if (row == 3'd7) begin
                                frame_done <= 1'b1;
                                if (pend) begin
                                    disp_buf <= pend_buf;
                                    pend     <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        row_sel <= '0;
                        col     <= '0;
                    end
                endcase
            end

            // Placed after the swap so a coincident generation survives in pending.
            if (gs.grid_valid) begin
                pend_buf   <= gs.grid;
                pend       <= 1'b1;
                live_count <= popcount(gs.grid);
                extinct    <= (gs.grid == 64'd0);
                stable     <= (gs.grid == prev_gen);
                prev_gen   <= gs.grid;
                gen_count  <= sat_inc(gen_count);
            end
        end
    end

    assign gs.row_sel    = row_sel;
    assign gs.col        = col;
    assign gs.frame_done = frame_done;
    assign gs.live_count = live_count;
    assign gs.stable     = stable;
    assign gs.extinct    = extinct;
    assign gs.gen_count  = gen_count;

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan with ROW_CYCLES=4, BLANK_CYCLES=2 (48-cycle frames).
module tb_grid_scan;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    grid_scan_if gs_if ();

    grid_scan #(
        .ROW_CYCLES  (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gs   (gs_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] PATTERN = 64'h0412_6424_0034_3c28;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        gs_if.enable = 1'b1;
        gs_if.grid = 64'hFFFF_FFFF_FFFF_FFFF;
        gs_if.grid_valid = 1'b1;
        tick(3);
        checks++; if (gs_if.row_sel !== 8'h00) begin errors++; $display("FAIL rst_row_sel got %h exp 00", gs_if.row_sel); end
        checks++; if (gs_if.col !== 8'h00) begin errors++; $display("FAIL rst_col got %h exp 00", gs_if.col); end
        checks++; if (gs_if.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", gs_if.frame_done); end
        checks++; if (gs_if.live_count !== 7'd0) begin errors++; $display("FAIL rst_live got %0d exp 0", gs_if.live_count); end
        checks++; if (gs_if.stable !== 1'b0) begin errors++; $display("FAIL rst_stable got %b exp 0", gs_if.stable); end
        checks++; if (gs_if.extinct !== 1'b1) begin errors++; $display("FAIL rst_extinct got %b exp 1", gs_if.extinct); end
        checks++; if (gs_if.gen_count !== 16'd0) begin errors++; $display("FAIL rst_gen got %h exp 0000", gs_if.gen_count); end
        gs_if.grid_valid = 1'b0;
        gs_if.grid = 64'd0;
        reset = 1'b1;
        tick(1);
        checks++; if (gs_if.row_sel !== 8'h00) begin errors++; $display("FAIL rel_blank got %h exp 00", gs_if.row_sel); end
        tick(1);
        checks++; if (gs_if.row_sel !== 8'h01) begin errors++; $display("FAIL rel_row0 got %h exp 01", gs_if.row_sel); end
        checks++; if (gs_if.col !== 8'h00) begin errors++; $display("FAIL rel_col got %h exp 00", gs_if.col); end
    endtask

    task automatic test_scan;
        logic [63:0] p;
        p = PATTERN;
        gs_if.grid = p;
        gs_if.grid_valid = 1'b1;
        tick(1);
        gs_if.grid_valid = 1'b0;
        checks++; if (gs_if.live_count !== 7'd17) begin errors++; $display("FAIL scan_live got %0d exp 17", gs_if.live_count); end
        checks++; if (gs_if.extinct !== 1'b0) begin errors++; $display("FAIL scan_extinct got %b exp 0", gs_if.extinct); end
        checks++; if (gs_if.gen_count !== 16'd1) begin errors++; $display("FAIL scan_gen got %0d exp 1", gs_if.gen_count); end
        tick(44);
        checks++; if (gs_if.frame_done !== 1'b0) begin errors++; $display("FAIL scan_fd_early got %b exp 0", gs_if.frame_done); end
        tick(1);
        checks++; if (gs_if.frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd got %b exp 1", gs_if.frame_done); end
        for (int r = 0; r < 8; r++) begin
            tick(2);
            checks++; if (gs_if.row_sel !== 8'(1 << r)) begin errors++; $display("FAIL scan_row%0d_sel got %h exp %h", r, gs_if.row_sel, 8'(1 << r)); end
            checks++; if (gs_if.col !== p[8*(7-r) +: 8]) begin errors++; $display("FAIL scan_row%0d_col got %h exp %h", r, gs_if.col, p[8*(7-r) +: 8]); end
            tick(3);
            checks++; if (gs_if.row_sel !== 8'(1 << r)) begin errors++; $display("FAIL scan_row%0d_hold got %h exp %h", r, gs_if.row_sel, 8'(1 << r)); end
            tick(1);
            checks++; if (gs_if.row_sel !== 8'h00 || gs_if.col !== 8'h00) begin errors++; $display("FAIL scan_row%0d_blank got %h/%h exp 00/00", r, gs_if.row_sel, gs_if.col); end
        end
        checks++; if (gs_if.frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd2 got %b exp 1", gs_if.frame_done); end
    endtask

    task automatic test_midframe;
        logic [63:0] p;
        p = PATTERN;
        tick(20);
        checks++; if (gs_if.row_sel !== 8'h08 || gs_if.col !== 8'h24) begin errors++; $display("FAIL mid_row3 got %h/%h exp 08/24", gs_if.row_sel, gs_if.col); end
        gs_if.grid = 64'd0;
        gs_if.grid_valid = 1'b1;
        tick(1);
        gs_if.grid_valid = 1'b0;
        checks++; if (gs_if.extinct !== 1'b1) begin errors++; $display("FAIL mid_extinct got %b exp 1", gs_if.extinct); end
        checks++; if (gs_if.live_count !== 7'd0) begin errors++; $display("FAIL mid_live got %0d exp 0", gs_if.live_count); end
        checks++; if (gs_if.stable !== 1'b0) begin errors++; $display("FAIL mid_stable got %b exp 0", gs_if.stable); end
        checks++; if (gs_if.gen_count !== 16'd2) begin errors++; $display("FAIL mid_gen got %0d exp 2", gs_if.gen_count); end
        tick(3);
        for (int r = 4; r < 8; r++) begin
            tick(2);
            checks++; if (gs_if.col !== p[8*(7-r) +: 8]) begin errors++; $display("FAIL mid_old_row%0d got %h exp %h", r, gs_if.col, p[8*(7-r) +: 8]); end
            tick(4);
        end
        checks++; if (gs_if.frame_done !== 1'b1) begin errors++; $display("FAIL mid_fd got %b exp 1", gs_if.frame_done); end
        for (int r = 0; r < 8; r++) begin
            tick(2);
            checks++; if (gs_if.row_sel !== 8'(1 << r) || gs_if.col !== 8'h00) begin errors++; $display("FAIL mid_new_row%0d got %h/%h exp %h/00", r, gs_if.row_sel, gs_if.col, 8'(1 << r)); end
            tick(4);
        end
    endtask

    task automatic test_stats;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        gs_if.grid = 64'h18;
        gs_if.grid_valid = 1'b1;
        tick(1);
        checks++; if (gs_if.stable !== 1'b0 || gs_if.live_count !== 7'd2) begin errors++; $display("FAIL st_first got stable=%b live=%0d exp 0/2", gs_if.stable, gs_if.live_count); end
        tick(1);
        checks++; if (gs_if.stable !== 1'b1) begin errors++; $display("FAIL st_same_stable got %b exp 1", gs_if.stable); end
        checks++; if (gs_if.live_count !== 7'd2) begin errors++; $display("FAIL st_same_live got %0d exp 2", gs_if.live_count); end
        gs_if.grid = 64'h38;
        tick(1);
        gs_if.grid_valid = 1'b0;
        checks++; if (gs_if.stable !== 1'b0) begin errors++; $display("FAIL st_diff_stable got %b exp 0", gs_if.stable); end
        checks++; if (gs_if.live_count !== 7'd3) begin errors++; $display("FAIL st_diff_live got %0d exp 3", gs_if.live_count); end
        checks++; if (gs_if.gen_count !== 16'd3) begin errors++; $display("FAIL st_gen got %0d exp 3", gs_if.gen_count); end
        tick(41);
        checks++; if (gs_if.row_sel !== 8'h80 || gs_if.col !== 8'h00) begin errors++; $display("FAIL st_cur_row7 got %h/%h exp 80/00", gs_if.row_sel, gs_if.col); end
        tick(48);
        checks++; if (gs_if.row_sel !== 8'h80 || gs_if.col !== 8'h38) begin errors++; $display("FAIL st_last_wins got %h/%h exp 80/38", gs_if.row_sel, gs_if.col); end
    endtask

    task automatic test_collision;
        gs_if.grid = 64'h8100_0000_0000_0000;
        gs_if.grid_valid = 1'b1;
        tick(1);
        gs_if.grid_valid = 1'b0;
        tick(2);
        gs_if.grid = 64'h4200_0000_0000_0000;
        gs_if.grid_valid = 1'b1;
        tick(1);
        gs_if.grid_valid = 1'b0;
        checks++; if (gs_if.frame_done !== 1'b1) begin errors++; $display("FAIL col_fd got %b exp 1", gs_if.frame_done); end
        checks++; if (gs_if.gen_count !== 16'd5) begin errors++; $display("FAIL col_gen got %0d exp 5", gs_if.gen_count); end
        tick(2);
        checks++; if (gs_if.row_sel !== 8'h01 || gs_if.col !== 8'h81) begin errors++; $display("FAIL col_old got %h/%h exp 01/81", gs_if.row_sel, gs_if.col); end
        tick(48);
        checks++; if (gs_if.row_sel !== 8'h01 || gs_if.col !== 8'h42) begin errors++; $display("FAIL col_new got %h/%h exp 01/42", gs_if.row_sel, gs_if.col); end
    endtask

    task automatic test_enable;
        tick(30);
        checks++; if (gs_if.row_sel !== 8'h20) begin errors++; $display("FAIL en_row5 got %h exp 20", gs_if.row_sel); end
        gs_if.enable = 1'b0;
        tick(1);
        checks++; if (gs_if.row_sel !== 8'h00 || gs_if.col !== 8'h00) begin errors++; $display("FAIL en_off got %h/%h exp 00/00", gs_if.row_sel, gs_if.col); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (gs_if.frame_done !== 1'b0 || gs_if.row_sel !== 8'h00) begin errors++; $display("FAIL en_idle%0d got fd=%b sel=%h exp 0/00", i, gs_if.frame_done, gs_if.row_sel); end
            tick(1);
        end
        gs_if.enable = 1'b1;
        tick(1);
        checks++; if (gs_if.frame_done !== 1'b1 || gs_if.row_sel !== 8'h00) begin errors++; $display("FAIL en_rise got fd=%b sel=%h exp 1/00", gs_if.frame_done, gs_if.row_sel); end
        tick(1);
        checks++; if (gs_if.frame_done !== 1'b0) begin errors++; $display("FAIL en_fd_pulse got %b exp 0", gs_if.frame_done); end
        tick(1);
        checks++; if (gs_if.row_sel !== 8'h01 || gs_if.col !== 8'h42) begin errors++; $display("FAIL en_row0 got %h/%h exp 01/42", gs_if.row_sel, gs_if.col); end
    endtask

    task automatic test_saturation;
        bit found;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        gs_if.grid = 64'd0;
        gs_if.grid_valid = 1'b1;
        tick(1);
        checks++; if (gs_if.stable !== 1'b1 || gs_if.extinct !== 1'b1) begin errors++; $display("FAIL sat_first_zero got stable=%b extinct=%b exp 1/1", gs_if.stable, gs_if.extinct); end
        tick(65533);
        checks++; if (gs_if.gen_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp FFFE", gs_if.gen_count); end
        tick(1);
        checks++; if (gs_if.gen_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp FFFF", gs_if.gen_count); end
        tick(2);
        gs_if.grid_valid = 1'b0;
        checks++; if (gs_if.gen_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFF", gs_if.gen_count); end
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (gs_if.row_sel !== 8'h00) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sat_find_row got timeout exp row driven"); end
        tick(1);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (gs_if.gen_count !== 16'd0) begin errors++; $display("FAIL async_gen got %h exp 0000", gs_if.gen_count); end
        checks++; if (gs_if.row_sel !== 8'h00) begin errors++; $display("FAIL async_row_sel got %h exp 00", gs_if.row_sel); end
        checks++; if (gs_if.extinct !== 1'b1) begin errors++; $display("FAIL async_extinct got %b exp 1", gs_if.extinct); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        gs_if.enable = 1'b0;
        gs_if.grid = 64'd0;
        gs_if.grid_valid = 1'b0;
        test_reset();
        test_scan();
        test_midframe();
        test_stats();
        test_collision();
        test_enable();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_scan.md
Name: grid_scan

Overview:
- Downstream consumer of the 64-bit Game-of-Life generation register.
- Time-multiplexes the 8x8 grid onto an LED matrix, one row at a time, with a blanking gap between rows to prevent ghosting.
- Double-buffers incoming generations so a frame never tears.
- Produces per-generation status (live count, still-life, extinction, generation counter) for the top-level FSM and LEDs.

Parameters:
- ROW_CYCLES, 1024, clk cycles each row is driven (>=1).
- BLANK_CYCLES, 16, clk cycles of blanking before each row (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- grid  input  64  current generation; row r = grid[8*(7-r)+7 : 8*(7-r)], column c = bit 7-c of that byte
- grid_valid  input  1  one-cycle pulse: a new generation is on grid (driven by the slow clock-enable)
- enable  input  1  1 = scan active, 0 = display off
- row_sel  output  8  one-hot active-high row drive, bit r = row r
- col  output  8  active-high column data for the driven row, col[7] = column 0
- frame_done  output  1  one-cycle pulse at each frame boundary
- live_count  output  7  population of the last captured generation, 0..64
- stable  output  1  last captured generation equals the one before it
- extinct  output  1  last captured generation is all zero
- gen_count  output  16  grid_valid pulses since reset, saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async), all held until reset deasserts:
  - state=BLANK, row index=0, cycle counter=0
  - pending buffer, display buffer and previous-generation register = 0; pending flag = 0
  - row_sel=0, col=0, frame_done=0, live_count=0, stable=0, extinct=1, gen_count=0
- States:
  - IDLE: enable=0. row_sel=0, col=0, counters held at 0.
  - BLANK: row_sel=0, col=0 for BLANK_CYCLES cycles, then -> DRIVE, same row.
  - DRIVE: row_sel=1<<r, col = display buffer row r, for ROW_CYCLES cycles. Then r=(r+1) mod 8 -> BLANK. Row 7 wraps to row 0.
- Frame boundary = transition DRIVE row7 -> BLANK row0, or IDLE -> BLANK row0. On that clock edge:
  - frame_done=1 for exactly one cycle.
  - If pending flag set: display buffer <= pending buffer, pending flag cleared.
- Outputs are registered: row_sel/col change on the edge the state changes.
- Frame length = 8*(BLANK_CYCLES+ROW_CYCLES) cycles.
- enable falls in any state: -> IDLE on the next edge; outputs 0 that cycle onward; no frame_done. Buffers, pending flag and stats are kept.
- enable rises: IDLE -> BLANK row 0 (frame boundary rules apply).
- grid_valid=1 on an edge (processed regardless of enable):
  - pending buffer <= grid; pending flag <= 1.
  - live_count <= popcount(grid).
  - extinct <= (grid==0).
  - stable <= (grid == previous register); previous register <= grid.
  - gen_count <= gen_count+1, unless already FFFF.
- Several grid_valid pulses within one frame: last one wins for display; every pulse updates stats and gen_count.
- grid_valid on the same edge as a frame boundary: swap uses the old pending contents. The new grid goes to pending, flag stays 1, and it is shown next frame.
- The first generation after reset compares against 0: stable=1 iff grid==0.
- Reset asserted mid-row or mid-frame: immediate return to reset values; scan restarts at BLANK row 0 after release.

Test Plan:
1. Hold reset=0 with grid=64'hFFFF_FFFF_FFFF_FFFF and grid_valid=1 -> all outputs at reset values, extinct=1, gen_count=0. Release with enable=1 -> row_sel=0 for 16 cycles, then row_sel=8'h01 with col=8'h00.
2. ROW_CYCLES=4, BLANK_CYCLES=2: grid_valid pulse with grid=64'h0412_6424_0034_3c28, enable=1 -> from the next frame, rows 0..7 show col=04,12,64,24,00,34,3C,28. Each row is held 4 cycles after a 2-cycle blank; frame_done fires every 48 cycles.
3. Mid-frame (row 3 driving): pulse grid_valid with grid=64'h0 -> rows 3..7 of the current frame still show the old pattern; the next frame is all-zero col; extinct=1, live_count=0.
4. Two consecutive pulses with grid=64'h0000_0000_0000_0018 (equal values) -> after the second, stable=1 and live_count=2. A third pulse with 64'h0000_0000_0000_0038 -> stable=0, live_count=3, gen_count=3.
5. Drop enable during DRIVE of row 5 -> next cycle row_sel=0, col=0, no frame_done. Re-raise enable -> frame_done pulse and BLANK on row 0.
6. Force gen_count to 16'hFFFE via 65534 pulses, then send 3 more -> gen_count stops at 16'hFFFF. Assert reset mid-row -> gen_count=0 and row_sel=0 immediately, without waiting for a clock edge.
